// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: pipeline request/response and data-memory bus signals of the load/store unit
interface mem_access_unit_if;
  logic        start;
  logic        we;
  logic        w;
  logic        h;
  logic        b;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        done;
  logic [31:0] load_data;
  logic        ld_w;
  logic        ld_h;
  logic        ld_b;
  logic        addr_err;
  logic        bus_err;
  modport master (
    input  start, we, w, h, b, addr, wdata, mem_ack, mem_rdata,
    output busy, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
           done, load_data, ld_w, ld_h, ld_b, addr_err, bus_err
  );
  modport slave (
    output start, we, w, h, b, addr, wdata, mem_ack, mem_rdata,
    input  busy, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
           done, load_data, ld_w, ld_h, ld_b, addr_err, bus_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit running one req/ack transaction per request
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input logic clk,
  input logic rst_n,
  mem_access_unit_if.master bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [3:0]       r_be;
  logic [31:0]      r_wdata;
  logic             r_sw, r_sh, r_sb;
  logic [1:0]       r_off;
  logic [31:0]      r_load_data;
  logic             r_ld_w, r_ld_h, r_ld_b;
  logic             r_addr_err;
  logic             r_bus_err;
  logic             w_is_w, w_is_h, w_is_b, w_mis, w_tmo;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic [CNT_W-1:0] w_cnt_nxt;
  // size decode with w>h>b priority; no flag at all means a word access
  assign w_is_w    = bus.w | ~(bus.h | bus.b);
  assign w_is_h    = ~bus.w & bus.h;
  assign w_is_b    = ~bus.w & ~bus.h & bus.b;
  assign w_mis     = (w_is_h & bus.addr[0]) | (w_is_w & |bus.addr[1:0]);
  assign w_be      = w_is_w ? 4'b1111 : w_is_h ? (bus.addr[1] ? 4'b1100 : 4'b0011) : 4'b0001 << bus.addr[1:0];
  assign w_wdata   = w_is_w ? bus.wdata : w_is_h ? {2{bus.wdata[15:0]}} : {4{bus.wdata[7:0]}};
  assign w_cnt_nxt = r_cnt + CNT_W'(1);
  assign w_tmo     = (TIMEOUT_CYCLES != 0) && (w_cnt_nxt == CNT_W'(TIMEOUT_CYCLES));
  // bus-facing outputs come straight from registered state so they are glitch-free
  assign bus.busy      = r_state != S_IDLE;
  assign bus.mem_req   = r_state == S_REQ;
  assign bus.done      = r_state == S_DONE;
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_be    = r_be;
  assign bus.mem_wdata = r_wdata;
  assign bus.load_data = r_load_data;
  assign bus.ld_w      = r_ld_w;
  assign bus.ld_h      = r_ld_h;
  assign bus.ld_b      = r_ld_b;
  assign bus.addr_err  = r_addr_err;
  assign bus.bus_err   = r_bus_err;
  // transaction FSM: accept in IDLE, wait for ack or timeout in REQ, pulse done in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_sw        <= 1'b0;
      r_sh        <= 1'b0;
      r_sb        <= 1'b0;
      r_off       <= '0;
      r_load_data <= '0;
      r_ld_w      <= 1'b0;
      r_ld_h      <= 1'b0;
      r_ld_b      <= 1'b0;
      r_addr_err  <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_addr_err <= 1'b0;
      r_bus_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start && w_mis) begin
            r_addr_err <= 1'b1;
          end else if (bus.start) begin
            r_we    <= bus.we;
            r_addr  <= {bus.addr[31:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_sw    <= w_is_w;
            r_sh    <= w_is_h;
            r_sb    <= w_is_b;
            r_off   <= bus.addr[1:0];
            r_cnt   <= '0;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.mem_ack) begin
            if (!r_we) r_load_data <= bus.mem_rdata >> {r_off, 3'b000};
            r_ld_w  <= r_sw;
            r_ld_h  <= r_sh;
            r_ld_b  <= r_sb;
            r_state <= S_DONE;
          end else if (w_tmo) begin
            r_bus_err <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized checks of mem_access_unit against a behavioural model
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tot = 0;
  int n_bad = 0;
  logic [31:0] exp_ld = '0;
  logic exp_w = 1'b0, exp_h = 1'b0, exp_b = 1'b0;
  always #5 clk = ~clk;
  mem_access_unit_if bus();
  mem_access_unit #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // d = REQ cycles before ack is presented; d >= 16 means no ack (timeout)
  task automatic run(input logic we, w, h, b, input logic [31:0] addr, wdata, rdata, input int d);
    logic sw, sh, sb;
    int off;
    logic [3:0] be;
    logic [31:0] wd;
    sw = w || !(h || b);
    sh = !w && h;
    sb = !w && !h && b;
    off = int'(addr % 4);
    be = sw ? 4'hF : sh ? (off >= 2 ? 4'hC : 4'h3) : 4'(1 << off);
    wd = sw ? wdata : sh ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
    bus.start = 1'b1; bus.we = we; bus.w = w; bus.h = h; bus.b = b;
    bus.addr = addr; bus.wdata = wdata;
    tick();
    if ((sh && off % 2 != 0) || (sw && off != 0)) begin
      chk("addr_err", bus.addr_err, 1);
      chk("mis_busy", bus.busy, 0);
      chk("mis_req", bus.mem_req, 0);
      bus.start = 1'b0;
      tick();
      chk("addr_err_pulse", bus.addr_err, 0);
      chk("mis_ld", bus.load_data, exp_ld);
      return;
    end
    chk("busy", bus.busy, 1);
    chk("mem_we", bus.mem_we, we);
    chk("mem_addr", bus.mem_addr, addr & ~32'h3);
    chk("mem_be", bus.mem_be, be);
    chk("mem_wdata", bus.mem_wdata, wd);
    for (int i = 0; i < 16; i++) begin
      chk("req_hold", bus.mem_req, 1);
      if (i == d) begin
        bus.mem_ack = 1'b1;
        bus.mem_rdata = rdata;
        tick();
        bus.mem_ack = 1'b0;
        bus.mem_rdata = $urandom;
        if (!we) exp_ld = rdata >> (8 * off);
        exp_w = sw; exp_h = sh; exp_b = sb;
        chk("done", bus.done, 1);
        chk("req_drop", bus.mem_req, 0);
        chk("bus_err_none", bus.bus_err, 0);
        chk("load_data", bus.load_data, exp_ld);
        chk("ld_flags", {bus.ld_w, bus.ld_h, bus.ld_b}, {exp_w, exp_h, exp_b});
        tick();
        chk("done_pulse", bus.done, 0);
        chk("idle_busy", bus.busy, 0);
        chk("idle_req", bus.mem_req, 0);
        bus.start = 1'b0;
        return;
      end
      chk("done_early", bus.done, 0);
      tick();
    end
    chk("bus_err", bus.bus_err, 1);
    chk("tmo_req", bus.mem_req, 0);
    chk("tmo_busy", bus.busy, 0);
    chk("tmo_done", bus.done, 0);
    bus.start = 1'b0;
    tick();
    chk("bus_err_pulse", bus.bus_err, 0);
    chk("tmo_ld", bus.load_data, exp_ld);
  endtask
  initial begin
    bus.start = 0; bus.we = 0; bus.w = 0; bus.h = 0; bus.b = 0;
    bus.addr = 0; bus.wdata = 0; bus.mem_ack = 0; bus.mem_rdata = 0;
    tick();
    tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_req", bus.mem_req, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_be", bus.mem_be, 0);
    chk("rst_ld", bus.load_data, 0);
    chk("rst_flags", {bus.done, bus.addr_err, bus.bus_err, bus.ld_w, bus.ld_h, bus.ld_b}, 0);
    rst_n = 1'b1;
    tick();
    run(0, 0, 0, 1, 32'h103, 32'h0, 32'hAABBCCDD, 2);
    run(1, 0, 1, 0, 32'h202, 32'h0000BEEF, 32'h11111111, 0);
    run(0, 1, 0, 0, 32'h006, 32'h0, 32'h0, 0);
    run(0, 0, 1, 0, 32'h011, 32'h0, 32'h0, 0);
    run(0, 1, 0, 0, 32'h300, 32'h0, 32'h0, 20);
    run(0, 1, 0, 0, 32'h304, 32'h0, 32'hCAFEF00D, 2);
    run(0, 0, 1, 0, 32'h502, 32'h0, 32'h89ABCDEF, 15);
    run(0, 0, 0, 0, 32'h600, 32'h0, 32'h0F1E2D3C, 1);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hDEADBEEF;
    tick();
    tick();
    bus.mem_ack = 1'b0;
    chk("ack_idle_busy", bus.busy, 0);
    chk("ack_idle_req", bus.mem_req, 0);
    chk("ack_idle_done", bus.done, 0);
    chk("ack_idle_ld", bus.load_data, exp_ld);
    bus.start = 1'b1; bus.we = 1'b0; bus.w = 1'b1; bus.h = 1'b0; bus.b = 1'b0; bus.addr = 32'h80;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    exp_ld = '0;
    chk("async_req", bus.mem_req, 0);
    chk("async_busy", bus.busy, 0);
    chk("async_ld", bus.load_data, 0);
    bus.start = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", bus.busy, 0);
    run(0, 1, 0, 0, 32'h40, 32'h0, 32'h12345678, 1);
    for (int k = 0; k < 40; k++) begin
      logic [2:0] sz;
      int d;
      sz = 3'($urandom);
      d = ($urandom % 8 == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 4));
      run(1'($urandom), sz[2], sz[1], sz[0], $urandom, $urandom, $urandom, d);
    end
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store unit in the MEM stage; sits directly upstream of the load-data width/sign extender.
- Takes a load/store request from the pipeline and runs one transaction on the word-wide data-memory bus, using a req/ack handshake.
- For stores, it generates byte enables and replicates write data across the lanes.
- For loads, it shifts the addressed bytes down to bit 0 and presents them, together with registered w/h/b flags, to the extender.
- Flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles in REQ without mem_ack before bus error; 0 disables the timeout.
- CNT_W, 5: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request valid from pipeline
- we  in  1  1=store, 0=load
- w  in  1  word access
- h  in  1  halfword access
- b  in  1  byte access
- addr  in  32  byte address
- wdata  in  32  store data, right-aligned
- busy  out  1  high while state!=IDLE; pipeline stalls
- mem_req  out  1  bus request
- mem_we  out  1  bus write enable
- mem_addr  out  32  word address, {addr[31:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  bus acknowledge, 1-cycle pulse
- mem_rdata  in  32  read data, valid with mem_ack
- done  out  1  1-cycle pulse, transaction complete
- load_data  out  32  right-aligned raw load data to extender
- ld_w  out  1  registered size flag, held with load_data
- ld_h  out  1  registered size flag, held with load_data
- ld_b  out  1  registered size flag, held with load_data
- addr_err  out  1  1-cycle pulse, misaligned request
- bus_err  out  1  1-cycle pulse, timeout

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs are 0, including load_data and the counter. mem_req drops immediately even mid-transaction; there is no partial completion.
- Size decode: priority w>h>b. If none of w/h/b is set, the access is a word.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - start is sampled only in IDLE.
  - Misaligned request (h with addr[0]=1, or word with addr[1:0]!=0): addr_err=1 next cycle, state stays IDLE, no bus activity, load_data unchanged.
  - Aligned request: register mem_we, mem_addr, mem_be, mem_wdata, the size flags and addr[1:0]; go to REQ. mem_req=1 from the next cycle.
- mem_be:
  - byte: 4'b0001<<addr[1:0]
  - halfword: addr[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
- mem_wdata:
  - byte: {4{wdata[7:0]}}
  - halfword: {2{wdata[15:0]}}
  - word: wdata
- REQ:
  - mem_req and all bus outputs are held stable until mem_ack.
  - On mem_ack: for loads, load_data = mem_rdata >> (8*addr[1:0]) with zero fill; for stores, load_data is unchanged. ld_w/ld_h/ld_b are updated for both. mem_req drops, go to DONE.
  - Counter increments each REQ cycle without ack. When TIMEOUT_CYCLES!=0 and the count reaches TIMEOUT_CYCLES, bus_err pulses, mem_req drops, state returns to IDLE, and done does not pulse.
  - mem_ack arriving in the same cycle as the timeout wins: normal completion, no bus_err.
  - The counter clears on entering REQ.
- DONE: done=1 for one cycle, then IDLE. start during DONE is ignored; the pipeline holds it because busy=1.
- busy = (state!=IDLE). It is registered and goes high the cycle after start is accepted. The pipeline must keep start and its operands stable until busy falls.
- mem_ack outside REQ is ignored.
- Latency: start accepted at cycle 0 → mem_req at cycle 1 → ack at cycle k≥1 → done and load_data at cycle k+1 → busy low at cycle k+2. Minimum 3 cycles.
- load_data, ld_w/ld_h/ld_b: hold their value until the next completed transaction.

Test Plan:
- Load byte at addr=0x103, mem_rdata=0xAABBCCDD, ack 2 cycles after req → mem_addr=0x100, mem_be=4'b1000, load_data=0x000000AA, ld_b=1, done at ack+1.
- Store halfword at addr=0x202, wdata=0x0000BEEF, immediate ack → mem_we=1, mem_be=4'b1100, mem_wdata=0xBEEFBEEF, done pulse, load_data unchanged.
- Load word at addr=0x006 → addr_err pulse next cycle, mem_req stays 0, busy stays 0.
- Load word, TIMEOUT_CYCLES=16, no ack → bus_err after 16 REQ cycles, mem_req=0, no done; a following request with ack at cycle 3 completes normally.
- rst_n low during REQ → mem_req, busy and load_data go 0 asynchronously; after release, a new load word at addr=0x40 with rdata 0x12345678 → load_data=0x12345678.
- start pulsed while busy, and mem_ack pulsed while in IDLE → no new transaction, no state change.
